// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus responder: FSM encoding, IO register
// offsets and the RAM/IO region select helper.
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [7:0] OFF_GPIO_OUT  = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN   = 8'h04;
    localparam logic [7:0] OFF_TMR_COUNT = 8'h08;
    localparam logic [7:0] OFF_TMR_CTRL  = 8'h0C;
    localparam logic [7:0] OFF_TMR_CMP   = 8'h10;

    // Only the top nibble decides between RAM and IO; everything else aliases.
    function automatic logic sel_io(input logic [31:0] addr, input logic [31:0] io_base);
        return (addr[31:28] == io_base[31:28]);
    endfunction

endpackage

// File: rtl/mio_timer.sv
// Free-running compare timer with sticky pending flag and registered interrupt.
// Only built when MIO_TIMER_EN is defined.
`ifdef MIO_TIMER_EN
module mio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr_count,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_cmp,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [1:0]  o_ctrl,
    output logic [31:0] o_cmp,
    output logic        o_irq
);

    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic [1:0]  r_ctrl;
    logic        r_pending;
    logic        r_irq;
    logic        w_hit;

    assign w_hit = r_ctrl[0] && (r_count == r_cmp);

    // Counter: a CPU write takes priority over increment and wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 32'h0;
        end else if (i_wr_count) begin
            r_count <= i_wdata;
        end else if (w_hit) begin
            r_count <= 32'h0;
        end else if (r_ctrl[0]) begin
            r_count <= r_count + 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // Pending flag: write-1-to-clear through ctrl bit 2 beats a same-cycle wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (i_wr_ctrl && i_wdata[2]) begin
            r_pending <= 1'b0;
        end else if (w_hit) begin
            r_pending <= 1'b1;
        end else begin
            r_pending <= r_pending;
        end
    end

    // Control/compare registers and the registered interrupt line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= 2'b00;
            r_cmp  <= 32'h0;
            r_irq  <= 1'b0;
        end else begin
            r_ctrl <= i_wr_ctrl ? i_wdata[1:0] : r_ctrl;
            r_cmp  <= i_wr_cmp  ? i_wdata      : r_cmp;
            r_irq  <= r_pending & r_ctrl[1];
        end
    end

    assign o_count = r_count;
    assign o_ctrl  = r_ctrl;
    assign o_cmp   = r_cmp;
    assign o_irq   = r_irq;

endmodule
`endif

// File: rtl/mio_bus_responder.sv
// Target side of the CPU memory/IO bus: word RAM plus GPIO and optional timer
// (MIO_TIMER_EN), one request per handshake with WAIT_CYCLES wait states.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter int          GPIO_W      = 16,
    parameter logic [31:0] IO_BASE     = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mio_req,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              bus_err,
    output logic              irq
);

    localparam int               CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [31:0]         r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_ready;
    logic [GPIO_W-1:0]   r_gpio_out;
    logic                r_bus_err;
    logic [31:0]         r_ram [2**RAM_AW];

    logic                w_capture;
    logic                w_commit;
    logic [31:0]         w_addr;
    logic                w_we;
    logic [31:0]         w_wdata;
    logic                w_is_io;
    logic [7:0]          w_io_off;
    logic [RAM_AW-1:0]   w_ram_idx;
    logic [31:0]         w_io_rd;
    logic                w_io_hit;
    logic [31:0]         w_rd_data;
    logic                w_io_wr;
    logic                w_wr_gpio;
    logic                w_unused_bits;

    assign w_capture = (r_state == ST_IDLE) && mio_req;
    // The access is performed on the edge entering RESP; with zero wait states
    // that is the capture edge itself, so the live request is used while IDLE.
    assign w_commit  = !reset && (r_state != ST_RESP) && (w_state_nxt == ST_RESP);
    assign w_addr    = (r_state == ST_IDLE) ? addr  : r_addr;
    assign w_we      = (r_state == ST_IDLE) ? mem_w : r_we;
    assign w_wdata   = (r_state == ST_IDLE) ? wdata : r_wdata;
    assign w_is_io   = sel_io(w_addr, IO_BASE);
    assign w_io_off  = {w_addr[7:2], 2'b00};
    assign w_ram_idx = w_addr[RAM_AW+1:2];
    assign w_io_wr   = w_commit && w_we && w_is_io;
    assign w_wr_gpio = w_io_wr && (w_io_off == OFF_GPIO_OUT);
    assign w_unused_bits = ^{w_addr, w_wdata};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mio_req) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt <= CNT_ONE) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture and wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= 32'h0;
            r_we       <= 1'b0;
            r_wdata    <= 32'h0;
            r_wait_cnt <= '0;
        end else if (w_capture) begin
            r_addr     <= addr;
            r_we       <= mem_w;
            r_wdata    <= wdata;
            r_wait_cnt <= WAIT_LOAD;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt - CNT_ONE;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

`ifdef MIO_TIMER_EN
    logic [31:0] w_tmr_count;
    logic [1:0]  w_tmr_ctrl;
    logic [31:0] w_tmr_cmp;
    logic        w_tmr_irq;

    mio_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_wr_count (w_io_wr && (w_io_off == OFF_TMR_COUNT)),
        .i_wr_ctrl  (w_io_wr && (w_io_off == OFF_TMR_CTRL)),
        .i_wr_cmp   (w_io_wr && (w_io_off == OFF_TMR_CMP)),
        .i_wdata    (w_wdata),
        .o_count    (w_tmr_count),
        .o_ctrl     (w_tmr_ctrl),
        .o_cmp      (w_tmr_cmp),
        .o_irq      (w_tmr_irq)
    );
    assign irq = w_tmr_irq;
`else
    assign irq = 1'b0;
`endif

    // IO read mux; unmatched offsets are the unmapped holes.
    always_comb begin
        w_io_rd  = 32'h0;
        w_io_hit = 1'b0;
        case (w_io_off)
            OFF_GPIO_OUT: begin
                w_io_hit = 1'b1;
                w_io_rd  = 32'(r_gpio_out);
            end
            OFF_GPIO_IN: begin
                w_io_hit = 1'b1;
                w_io_rd  = 32'(gpio_in);
            end
`ifdef MIO_TIMER_EN
            OFF_TMR_COUNT: begin
                w_io_hit = 1'b1;
                w_io_rd  = w_tmr_count;
            end
            OFF_TMR_CTRL: begin
                w_io_hit = 1'b1;
                w_io_rd  = 32'(w_tmr_ctrl);
            end
            OFF_TMR_CMP: begin
                w_io_hit = 1'b1;
                w_io_rd  = w_tmr_cmp;
            end
`endif
            default: begin
                w_io_hit = 1'b0;
                w_io_rd  = 32'h0;
            end
        endcase
    end

    assign w_rd_data = w_is_io ? w_io_rd : r_ram[w_ram_idx];

    // Data RAM: never cleared, write blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_is_io) begin
            r_ram[w_ram_idx] <= w_wdata;
        end
    end

    // Response registers, GPIO output and sticky bus error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_rdata    <= 32'h0;
            r_gpio_out <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_ready    <= w_commit;
            r_rdata    <= (w_commit && !w_we) ? w_rd_data : 32'h0;
            r_gpio_out <= w_wr_gpio ? w_wdata[GPIO_W-1:0] : r_gpio_out;
            r_bus_err  <= r_bus_err | (w_commit && w_is_io && !w_io_hit);
        end
    end

    assign rdata     = r_rdata;
    assign mio_ready = r_ready;
    assign gpio_out  = r_gpio_out;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench: one responder with one wait state and one with none.
module tb_mio_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, we1, ready1, berr1, irq1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [15:0] gpio_in1, gpio_out1;
    logic        req0, we0, ready0, berr0, irq0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [15:0] gpio_in0, gpio_out0;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] rd;
    int          lat;
    logic [31:0] t2_exp [3];

    always #5 clk = ~clk;

    mio_bus_responder #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst), .mio_req(req1), .mem_w(we1), .addr(addr1),
        .wdata(wdata1), .rdata(rdata1), .mio_ready(ready1), .gpio_in(gpio_in1),
        .gpio_out(gpio_out1), .bus_err(berr1), .irq(irq1)
    );

    mio_bus_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst), .mio_req(req0), .mem_w(we0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .mio_ready(ready0), .gpio_in(gpio_in0),
        .gpio_out(gpio_out0), .bus_err(berr0), .irq(irq0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One handshake; lat = edges from request to ready (99 if never seen).
    task automatic txn(input bit d0, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rdv, output int lt);
        @(negedge clk);
        if (d0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end
        lt = 99;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if ((d0 ? ready0 : ready1) === 1'b1) begin
                lt = i;
                break;
            end
        end
        rdv = d0 ? rdata0 : rdata1;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        check("ready_pulse_width", {31'h0, (d0 ? ready0 : ready1)}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; gpio_in1 = 16'hBEEF;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; gpio_in0 = 16'h0000;
        t2_exp[0] = 32'h1111_0000;
        t2_exp[1] = 32'h2222_0004;
        t2_exp[2] = 32'h3333_0008;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  {31'h0, ready1},     32'h0);
        check("rst_rdata",  rdata1,              32'h0);
        check("rst_gpio",   {16'h0, gpio_out1},  32'h0);
        check("rst_berr",   {31'h0, berr1},      32'h0);
        check("rst_irq",    {31'h0, irq1},       32'h0);
        check("rst0_flags", {28'h0, ready0, berr0, irq0, |gpio_out0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // One wait state: write then read back RAM, including aliased addresses.
        txn(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, rd, lat);
        check("t1_wr_latency", lat, 32'd2);
        txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, rd, lat);
        check("t1_rd_latency", lat, 32'd2);
        check("t1_rd_data", rd, 32'h1234_5678);
        txn(1'b0, 1'b0, 32'h0000_1043, 32'h0, rd, lat);
        check("t1_alias_data", rd, 32'h1234_5678);

        // Zero wait states: preload, then hold the request over three reads.
        txn(1'b1, 1'b1, 32'h0000_0000, t2_exp[0], rd, lat);
        check("t2_wr_latency", lat, 32'd1);
        txn(1'b1, 1'b1, 32'h0000_0004, t2_exp[1], rd, lat);
        txn(1'b1, 1'b1, 32'h0000_0008, t2_exp[2], rd, lat);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("t2_ready_pattern", {31'h0, ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) check("t2_rd_data", rdata0, t2_exp[k / 2]);
            @(negedge clk);
            if (k % 2 == 0) addr0 = 32'((k / 2 + 1) * 4);
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        check("t2_ready_after_drop", {31'h0, ready0}, 32'h0);

        // GPIO.
        txn(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_00A5, rd, lat);
        check("t3_gpio_out", {16'h0, gpio_out1}, 32'h0000_00A5);
        txn(1'b0, 1'b0, 32'hF000_0000, 32'h0, rd, lat);
        check("t3_gpio_out_rd", rd, 32'h0000_00A5);
        txn(1'b0, 1'b0, 32'hF000_0004, 32'h0, rd, lat);
        check("t3_gpio_in_rd", rd, 32'h0000_BEEF);
        check("t3_io_latency", lat, 32'd2);
        txn(1'b0, 1'b1, 32'hF000_0004, 32'h0000_1234, rd, lat);
        check("t3_ro_write_no_err", {31'h0, berr1}, 32'h0);

        // Unmapped IO offset: read 0, sticky error, write dropped.
        txn(1'b0, 1'b0, 32'hF000_0020, 32'h0, rd, lat);
        check("t4_unmapped_rd", rd, 32'h0);
        check("t4_berr_set", {31'h0, berr1}, 32'h1);
        txn(1'b0, 1'b1, 32'hF000_0024, 32'h0000_5A5A, rd, lat);
        check("t4_gpio_kept", {16'h0, gpio_out1}, 32'h0000_00A5);
        txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, rd, lat);
        check("t4_ram_still_ok", rd, 32'h1234_5678);
        check("t4_berr_sticky", {31'h0, berr1}, 32'h1);

        // Reset during the wait state of a write.
        txn(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, rd, lat);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0080; wdata1 = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        check("t6_in_wait", {31'h0, ready1}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        req1 = 1'b0;
        @(posedge clk); #1;
        check("t6_no_ready_rst", {31'h0, ready1}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t6_no_ready_after", {31'h0, ready1}, 32'h0);
        end
        check("t6_berr_cleared", {31'h0, berr1}, 32'h0);
        check("t6_gpio_cleared", {16'h0, gpio_out1}, 32'h0);
        txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, rd, lat);
        check("t6_ram_prior", rd, 32'hCAFE_F00D);

`ifdef MIO_TIMER_EN
        txn(1'b0, 1'b1, 32'hF000_0010, 32'h0000_0003, rd, lat);
        txn(1'b0, 1'b1, 32'hF000_000C, 32'h0000_0003, rd, lat);
        repeat (3) @(posedge clk);
        #1;
        check("t5_irq_not_yet", {31'h0, irq1}, 32'h0);
        @(posedge clk); #1;
        check("t5_irq_set", {31'h0, irq1}, 32'h1);
        txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, rd, lat);
        check("t5_count_wrapped", rd, 32'h0000_0002);
        txn(1'b0, 1'b0, 32'hF000_0010, 32'h0, rd, lat);
        check("t5_cmp_rd", rd, 32'h0000_0003);
        txn(1'b0, 1'b1, 32'hF000_000C, 32'h0000_0006, rd, lat);
        check("t5_irq_cleared", {31'h0, irq1}, 32'h0);
        txn(1'b0, 1'b0, 32'hF000_000C, 32'h0, rd, lat);
        check("t5_ctrl_rd", rd, 32'h0000_0002);
        check("t5_irq_stays_low", {31'h0, irq1}, 32'h0);
        txn(1'b0, 1'b1, 32'hF000_0008, 32'h0000_0055, rd, lat);
        txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, rd, lat);
        check("t5_count_wr_rd", rd, 32'h0000_0055);
        check("t5_berr_clear", {31'h0, berr1}, 32'h0);
`else
        txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, rd, lat);
        check("nt_count_unmapped_rd", rd, 32'h0);
        check("nt_count_unmapped_err", {31'h0, berr1}, 32'h1);
        txn(1'b0, 1'b1, 32'hF000_000C, 32'h0000_0003, rd, lat);
        repeat (6) @(posedge clk);
        #1;
        check("nt_irq_tied_low", {31'h0, irq1}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
